// File: rtl/button_press_classifier.sv
// Turns the debounced button level into press / short-click / long-press / repeat / release strobes.
// Latency: every strobe and `held` is registered, one clk after the sampled condition.
// Backpressure: none; strobes are single-cycle and downstream must take them when they appear.
module button_press_classifier #(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int CNT_W     = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1ms,
    input  logic debounced,
    output logic press_pulse,
    output logic short_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        LOCKOUT = 2'd0,
        IDLE    = 2'd1,
        HOLD    = 2'd2,
        REPEAT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] ms_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= LOCKOUT;
            ms_cnt        <= '0;
            press_pulse   <= 1'b0;
            short_click   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            short_click   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                // A button held through reset must be let go before it can count.
                LOCKOUT: begin
                    if (!debounced) begin
                        state  <= IDLE;
                        ms_cnt <= '0;
                    end
                end
                IDLE: begin
                    if (debounced) begin
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                        state       <= HOLD;
                        ms_cnt      <= '0;
                    end
                end
                HOLD: begin
                    if (!debounced) begin
                        short_click   <= 1'b1;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        state         <= IDLE;
                        ms_cnt        <= '0;
                    end else if (tick_1ms) begin
                        if (ms_cnt == LONG_LAST) begin
                            long_press <= 1'b1;
                            state      <= REPEAT;
                            ms_cnt     <= '0;
                        end else begin
                            ms_cnt <= ms_cnt + CNT_ONE;
                        end
                    end
                end
                REPEAT: begin
                    if (!debounced) begin
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        state         <= IDLE;
                        ms_cnt        <= '0;
                    end else if (tick_1ms) begin
                        if (ms_cnt == REPEAT_LAST) begin
                            repeat_pulse <= 1'b1;
                            ms_cnt       <= '0;
                        end else begin
                            ms_cnt <= ms_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state  <= LOCKOUT;
                    ms_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_classifier.sv
module tb_button_press_classifier;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick_1ms = 1'b0;
    logic debounced = 1'b0;
    logic press_pulse, short_click, long_press, repeat_pulse, release_pulse, held;

    button_press_classifier #(.LONG_MS(5), .REPEAT_MS(3), .CNT_W(11)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_1ms      (tick_1ms),
        .debounced     (debounced),
        .press_pulse   (press_pulse),
        .short_click   (short_click),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .release_pulse (release_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int tick_num = 0;
    int ev_cnt[5] = '{default: 0};
    int base[5]   = '{default: 0};
    int rep_hist[16] = '{default: 0};
    int long_at = -1;
    int excl_err = 0;

    // Event indices: 0 press, 1 short, 2 long, 3 repeat, 4 release.
    always @(negedge clk) begin
        int n;
        n = int'(press_pulse) + int'(short_click) + int'(long_press)
          + int'(repeat_pulse) + int'(release_pulse);
        if (n > 1 && !(n == 2 && short_click && release_pulse)) excl_err++;
        if (short_click && !release_pulse) excl_err++;
        if (release_pulse && held) excl_err++;
        if (press_pulse && !held) excl_err++;
        if (press_pulse)   ev_cnt[0]++;
        if (short_click)   ev_cnt[1]++;
        if (long_press) begin
            ev_cnt[2]++;
            long_at = tick_num;
        end
        if (repeat_pulse) begin
            if (ev_cnt[3] < 16) rep_hist[ev_cnt[3]] = tick_num;
            ev_cnt[3]++;
        end
        if (release_pulse) ev_cnt[4]++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        for (int i = 0; i < 5; i++) base[i] = ev_cnt[i];
    endtask

    function automatic int delta(input int idx);
        return ev_cnt[idx] - base[idx];
    endfunction

    // One tick every 4 clk.
    task automatic hold_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1ms = 1'b1;
            tick_num++;
            cyc();
            tick_1ms = 1'b0;
            repeat (3) cyc();
        end
    endtask

    task automatic release_btn();
        debounced = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        int b;

        // Reset with button held: no events, then a clean re-press counts once.
        rst = 1'b0;
        debounced = 1'b1;
        repeat (3) cyc();
        check("rst_press",   int'(press_pulse), 0);
        check("rst_short",   int'(short_click), 0);
        check("rst_long",    int'(long_press), 0);
        check("rst_repeat",  int'(repeat_pulse), 0);
        check("rst_release", int'(release_pulse), 0);
        check("rst_held",    int'(held), 0);
        mark();
        rst = 1'b1;
        hold_ticks(20);
        check("lockout_press",   delta(0), 0);
        check("lockout_release", delta(4), 0);
        check("lockout_held",    int'(held), 0);
        debounced = 1'b0;
        cyc();
        debounced = 1'b1;
        repeat (2) cyc();
        check("repress_count", delta(0), 1);
        check("repress_held",  int'(held), 1);
        release_btn();

        // Short click: 3 ticks then release.
        mark();
        tick_num = 0;
        debounced = 1'b1;
        cyc();
        check("short_press_now", int'(press_pulse), 1);
        hold_ticks(3);
        debounced = 1'b0;
        cyc();
        check("short_click_now", int'(short_click), 1);
        check("short_rel_now",   int'(release_pulse), 1);
        check("short_held_low",  int'(held), 0);
        repeat (2) cyc();
        check("short_press", delta(0), 1);
        check("short_short", delta(1), 1);
        check("short_long",  delta(2), 0);
        check("short_rel",   delta(4), 1);

        // Long hold for 14 ticks: long on 5, repeats on 8, 11, 14.
        mark();
        tick_num = 0;
        long_at = -1;
        debounced = 1'b1;
        cyc();
        hold_ticks(14);
        b = base[3];
        check("long_count",   delta(2), 1);
        check("long_tick",    long_at, 5);
        check("rep_count",    delta(3), 3);
        check("rep_tick0",    rep_hist[b], 8);
        check("rep_tick1",    rep_hist[b + 1], 11);
        check("rep_tick2",    rep_hist[b + 2], 14);
        check("long_held",    int'(held), 1);
        release_btn();
        check("long_rel",     delta(4), 1);
        check("long_short",   delta(1), 0);
        check("long_held_lo", int'(held), 0);

        // Release lands on the 5th tick: release wins.
        mark();
        tick_num = 0;
        debounced = 1'b1;
        cyc();
        hold_ticks(4);
        tick_1ms = 1'b1;
        debounced = 1'b0;
        cyc();
        tick_1ms = 1'b0;
        repeat (2) cyc();
        check("coin_short", delta(1), 1);
        check("coin_rel",   delta(4), 1);
        check("coin_long",  delta(2), 0);
        check("coin_held",  int'(held), 0);

        // Asynchronous reset while a repeat strobe is high.
        tick_num = 0;
        debounced = 1'b1;
        cyc();
        hold_ticks(7);
        tick_1ms = 1'b1;
        tick_num++;
        cyc();
        tick_1ms = 1'b0;
        check("pre_rst_repeat", int'(repeat_pulse), 1);
        check("pre_rst_held",   int'(held), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_repeat", int'(repeat_pulse), 0);
        check("async_held",   int'(held), 0);
        mark();
        repeat (2) cyc();
        rst = 1'b1;
        hold_ticks(3);
        check("post_rst_rel",   delta(4), 0);
        check("post_rst_press", delta(0), 0);
        debounced = 1'b0;
        cyc();
        debounced = 1'b1;
        repeat (2) cyc();
        check("post_rst_repress", delta(0), 1);
        release_btn();

        // Tick coincident with the press edge is not counted.
        mark();
        tick_num = 0;
        long_at = -1;
        debounced = 1'b1;
        tick_1ms = 1'b1;
        cyc();
        tick_1ms = 1'b0;
        repeat (3) cyc();
        hold_ticks(4);
        check("edge_long_early", delta(2), 0);
        hold_ticks(1);
        check("edge_long_count", delta(2), 1);
        check("edge_long_tick",  long_at, 5);
        release_btn();

        check("exclusivity", excl_err, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_press_classifier.md
# button_press_classifier

Consumes the debounced button level produced by the 10 ms debounce shift register and turns it into single-cycle user-intent events for the alarm-clock control logic. Events are press, short click, long press, auto-repeat while held, and release. It shares the 1 ms tick that drives the debouncer's load. Downstream time-set and alarm-set logic use `short_click` to step a digit and `repeat_pulse` to scroll it quickly.

## Interface
- `LONG_MS`, default 1000: held time in ms before `long_press` fires; legal range 2..2^CNT_W-1.
- `REPEAT_MS`, default 200: interval in ms between `repeat_pulse` events after `long_press`; legal range 1..2^CNT_W-1.
- `CNT_W`, default 11: width of the ms counter.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `tick_1ms` input 1: one-`clk`-wide strobe, once per ms.
- `debounced` input 1: debounced button level (1 = held), synchronous to `clk`.
- `press_pulse` output 1: one-cycle strobe on an accepted press.
- `short_click` output 1: one-cycle strobe on release before `long_press`.
- `long_press` output 1: one-cycle strobe when the hold reaches `LONG_MS`.
- `repeat_pulse` output 1: one-cycle strobe every `REPEAT_MS` after `long_press`.
- `release_pulse` output 1: one-cycle strobe on any release of an accepted press.
- `held` output 1: level, high in states HOLD and REPEAT.

## Operation
- FSM states: LOCKOUT, IDLE, HOLD, REPEAT.
- Register `ms_cnt[CNT_W-1:0]` is cleared on every state entry.
- **LOCKOUT** (reset state): no outputs. Go to IDLE on the first cycle `debounced`=0. A button held through reset is never reported as a press.
- **IDLE**: if `debounced`=1, assert `press_pulse`, go to HOLD, clear `ms_cnt`.
- **HOLD**:
  - If `debounced`=0: assert `short_click` and `release_pulse`, go to IDLE.
  - Else on `tick_1ms`: if `ms_cnt`==LONG_MS-1, assert `long_press`, go to REPEAT, clear `ms_cnt`; otherwise increment `ms_cnt`.
- **REPEAT**:
  - If `debounced`=0: assert `release_pulse` only (no `short_click`), go to IDLE.
  - Else on `tick_1ms`: if `ms_cnt`==REPEAT_MS-1, assert `repeat_pulse` and clear `ms_cnt`; otherwise increment.
- Priority in any cycle: release beats tick. If `debounced`=0 and `tick_1ms`=1 in the same cycle, the release is handled and no `long_press` or `repeat_pulse` fires.
- A `tick_1ms` in the cycle of the press edge (the IDLE→HOLD cycle) is not counted.
- `ms_cnt` never wraps: it is bounded by the compares above. Out-of-range parameters are illegal and need no defined behaviour.
- Events are mutually exclusive, except that `short_click` and `release_pulse` coincide.

## Timing
- All outputs are registered.
- Every strobe is high exactly one `clk` cycle, in the cycle after the `clk` edge at which the triggering condition was sampled.
- Press latency: `debounced` sampled 1 at edge N, so `press_pulse` is high during cycle N+1 and `held` is high from cycle N+1.
- `long_press` comes exactly LONG_MS counted ticks after the press edge. `repeat_pulse` comes every REPEAT_MS ticks after that.
- Release latency: one `clk`, same as press. `held` is low in the same cycle as `release_pulse`.
- Reset values: state LOCKOUT, `ms_cnt`=0, all outputs 0.
- Reset asserted mid-hold clears everything at once, with no release event. After reset, a new press needs `debounced` to go low, then high.

## Test plan
- **Reset with button held.** `rst`=0 while `debounced`=1, then release `rst` with the button still held for 20 ticks → no output strobes. Then `debounced`=0 for 1 cycle and 1 again → exactly one `press_pulse`.
- **Short click** (LONG_MS=5, REPEAT_MS=3, tick every 4 clk). Hold for 3 ticks, then release → `press_pulse`, then one cycle with `short_click`=`release_pulse`=1; no `long_press`.
- **Long hold with repeats** (same parameters). Hold for 14 ticks → `long_press` on tick 5; `repeat_pulse` on ticks 8, 11, 14. On release: `release_pulse`=1, `short_click`=0.
- **Release coincident with tick.** Drop `debounced` in the same cycle as the 5th tick → `short_click` and `release_pulse`, and no `long_press`.
- **Reset mid-REPEAT.** Pull `rst` low asynchronously between clock edges → all outputs 0 immediately, no `release_pulse`, state LOCKOUT.
- **Tick on the press edge cycle.** Press in the same cycle as a tick → that tick is not counted; `long_press` fires on the 5th subsequent tick.
